// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encodings and requester indices.
// No logic; latency and backpressure are properties of the modules that import this.
// Requester indices double as the one-bit owner/last-grant encoding.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, on a tie the one not granted last wins.
// Latency: combinational.
// Backpressure: none; grant is all-zero when nothing is valid.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == REQ1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters; optional perf counters via ALU_ARB_PERF_EN.
// Latency: accept cycle, one EXEC cycle, then response valid; minimum 3 cycles per transaction.
// Backpressure: one transaction in flight; req_ready held low until the owner takes its response.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 4
`ifdef ALU_ARB_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [DW-1:0]  req_a0,
    input  logic [DW-1:0]  req_a1,
    input  logic [DW-1:0]  req_b0,
    input  logic [DW-1:0]  req_b1,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_c,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_conflict
`endif
);

    state_t     state, state_nxt;
    logic       owner;
    logic       last_grant;
    logic [1:0] grant;
    logic       accept;
    logic       gsel;

    rr_arb2 u_rr (
        .valid (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign accept = (state == IDLE) && (grant != 2'b00);
    assign gsel   = grant[REQ1];
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant != 2'b00) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers only load on accept so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_data   <= '0;
            owner      <= REQ0;
            last_grant <= REQ1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_a      <= gsel ? req_a1  : req_a0;
                alu_b      <= gsel ? req_b1  : req_b0;
                alu_op     <= gsel ? req_op1 : req_op0;
                owner      <= gsel;
                last_grant <= gsel;
            end
            if (state == EXEC) rsp_data <= alu_c;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic conflict_evt;
    assign conflict_evt = ((state == IDLE) && (req_valid == 2'b11)) ||
                          (busy && (req_valid != 2'b00));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (accept && !gsel && !(&perf_grant0))  perf_grant0   <= perf_grant0 + 1'b1;
            if (accept &&  gsel && !(&perf_grant1))  perf_grant1   <= perf_grant1 + 1'b1;
            if (conflict_evt && !(&perf_conflict))   perf_conflict <= perf_conflict + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model of grant order and ALU results.
module tb_alu_share_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic           clk;
    logic           reset_n;
    logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0]  req_a0, req_a1, req_b0, req_b1;
    logic [OPW-1:0] req_op0, req_op1, alu_op;
    logic [DW-1:0]  alu_a, alu_b, alu_c, rsp_data;
    logic           busy;
`ifdef ALU_ARB_PERF_EN
    logic [2:0]     perf_grant0, perf_grant1, perf_conflict;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic m_last   = 1'b1;
    bit   quiet    = 1'b0;

    alu_share_arbiter #(
        .DW  (DW),
        .OPW (OPW)
`ifdef ALU_ARB_PERF_EN
        , .CNT_W (3)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    // Stand-in for the parent's shared ALU.
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OPW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_c = alu_fn(alu_a, alu_b, alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic scramble_operands();
        req_a0  = $urandom;  req_b0 = $urandom;  req_op0 = 4'($urandom);
        req_a1  = $urandom;  req_b1 = $urandom;  req_op1 = 4'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        m_last  = 1'b1;
    endtask

    task automatic do_txn(input logic [1:0] vld,
                          input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [OPW-1:0] op0,
                          input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [OPW-1:0] op1,
                          input int hold);
        logic           g;
        logic [1:0]     oh;
        logic [DW-1:0]  ea, eb, exp_c;
        logic [OPW-1:0] eop;
        g     = (vld == 2'b11) ? ~m_last : vld[1];
        oh    = g ? 2'b10 : 2'b01;
        ea    = g ? a1 : a0;
        eb    = g ? b1 : b0;
        eop   = g ? op1 : op0;
        exp_c = alu_fn(ea, eb, eop);

        @(negedge clk);
        req_valid = vld;
        req_a0 = a0; req_b0 = b0; req_op0 = op0;
        req_a1 = a1; req_b1 = b1; req_op1 = op1;
        rsp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== oh) begin failures++; $display("FAIL grant_ready: got=%b exp=%b", req_ready, oh); end

        @(posedge clk); #1;
        m_last = g;
        scramble_operands();
        req_valid = quiet ? 2'b00 : 2'b11;
        #1;
        checks++;
        if (alu_a !== ea || alu_b !== eb || alu_op !== eop) begin
            failures++;
            $display("FAIL latch_operands: got=%h/%h/%h exp=%h/%h/%h", alu_a, alu_b, alu_op, ea, eb, eop);
        end
        checks++;
        if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            failures++;
            $display("FAIL exec_state: busy=%b ready=%b rsp_valid=%b exp 1/00/00", busy, req_ready, rsp_valid);
        end
        req_valid = quiet ? 2'b00 : 2'($urandom);

        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== oh || rsp_data !== exp_c) begin
            failures++;
            $display("FAIL response: rsp_valid=%b data=%h exp %b/%h", rsp_valid, rsp_data, oh, exp_c);
        end

        for (int i = 0; i < hold; i++) begin
            rsp_ready = ~oh;
            req_valid = quiet ? 2'b00 : 2'($urandom);
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== oh || rsp_data !== exp_c || busy !== 1'b1 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall_hold: rsp_valid=%b data=%h busy=%b ready=%b exp %b/%h/1/00",
                         rsp_valid, rsp_data, busy, req_ready, oh, exp_c);
            end
        end

        rsp_ready = oh | (~oh & 2'($urandom));
        req_valid = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== exp_c || alu_a !== ea) begin
            failures++;
            $display("FAIL after_handshake: rsp_valid=%b busy=%b data=%h alu_a=%h exp 00/0/%h/%h",
                     rsp_valid, busy, rsp_data, alu_a, exp_c, ea);
        end
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        scramble_operands();
        #12;
        checks++;
        if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || rsp_data !== '0 ||
            rsp_valid !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_values: a=%h b=%h op=%h data=%h rv=%b busy=%b rdy=%b exp all zero",
                     alu_a, alu_b, alu_op, rsp_data, rsp_valid, busy, req_ready);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_tie: got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        m_last    = 1'b1;
    endtask

    task automatic test_single();
        do_txn(2'b01, 32'd5, 32'd3, OP_ADD, 32'd0, 32'd0, OP_ADD, 0);
        checks++;
        if (rsp_data !== 32'd8) begin failures++; $display("FAIL single_add: got=%h exp=%h", rsp_data, 32'd8); end
    endtask

    task automatic test_conflict();
        apply_reset();
        do_txn(2'b11, 32'd10, 32'd20, OP_ADD, 32'd2, 32'd7, OP_SUB, 1);
        checks++;
        if (rsp_data !== 32'd30) begin failures++; $display("FAIL conflict_req0_first: got=%h exp=%h", rsp_data, 32'd30); end
        do_txn(2'b11, 32'd10, 32'd20, OP_ADD, 32'd2, 32'd7, OP_SUB, 0);
        checks++;
        if (rsp_data !== 32'hFFFF_FFFB) begin
            failures++; $display("FAIL conflict_req1_sub: got=%h exp=FFFFFFFB", rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, $urandom, $urandom, 4'($urandom_range(0, 4)),
                   $urandom, $urandom, 4'($urandom_range(0, 4)), 0);
    endtask

    task automatic test_backpressure();
        do_txn(2'b10, 32'h0, 32'h0, OP_ADD, 32'hDEAD_0000, 32'h0000_BEEF, 4'd3, 5);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 2'b01;
        req_a0 = 32'h1234_5678; req_b0 = 32'h1; req_op0 = OP_ADD;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_reset_in_exec: busy=%b exp=1", busy); end
        reset_n   = 1'b0;
        req_valid = 2'b00;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || alu_a !== '0 || busy !== 1'b0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL mid_reset_clear: rv=%b alu_a=%h busy=%b data=%h exp 00/0/0/0",
                     rsp_valid, alu_a, busy, rsp_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_last  = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_reset_dropped: rv=%b busy=%b exp 00/0", rsp_valid, busy);
        end
        do_txn(2'b01, 32'd100, 32'd1, OP_SUB, 32'd0, 32'd0, OP_ADD, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            do_txn(2'($urandom_range(1, 3)), $urandom, $urandom, 4'($urandom),
                   $urandom, $urandom, 4'($urandom), $urandom_range(0, 3));
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf();
        apply_reset();
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) do_txn(2'b11, 32'd1, 32'd2, OP_ADD, 32'd3, 32'd4, OP_ADD, 0);
        quiet = 1'b0;
        checks++;
        if (perf_grant0 !== 3'd2 || perf_grant1 !== 3'd2 || perf_conflict !== 3'd4) begin
            failures++;
            $display("FAIL perf_counts: g0=%0d g1=%0d c=%0d exp 2/2/4", perf_grant0, perf_grant1, perf_conflict);
        end
        @(negedge clk);
        req_valid = 2'b11;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (perf_conflict !== 3'd7 || perf_grant0 !== 3'd3) begin
            failures++;
            $display("FAIL perf_saturate: c=%0d g0=%0d exp 7/3", perf_conflict, perf_grant0);
        end
        apply_reset();
        #1;
        checks++;
        if (perf_grant0 !== 3'd0 || perf_grant1 !== 3'd0 || perf_conflict !== 3'd0) begin
            failures++; $display("FAIL perf_reset: g0=%0d g1=%0d c=%0d exp 0", perf_grant0, perf_grant1, perf_conflict);
        end
    endtask
`endif

    initial begin
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
